// File: rtl/fcseq_pkg.sv
// fcseq_pkg: shared FSM encoding, accumulator default and 16-bit saturation limits
// for the fully-connected layer sequencer.
package fcseq_pkg;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_MAC   = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_OUT   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam int ACC_WIDTH_DEF = 24;
    localparam logic signed [15:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [15:0] SAT_MIN = 16'sh8000;
endpackage

// File: rtl/fcseq_mac.sv
// fcseq_mac: signed multiply, bias-load/accumulate and 16-bit saturation of one neuron.
// Optional ReLU on the saturated result when FCSEQ_RELU_EN is defined.
module fcseq_mac
    import fcseq_pkg::*;
#(
    parameter int DW        = 8,
    parameter int ACC_WIDTH = ACC_WIDTH_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_vld,
    input  logic          i_first,
    input  logic [DW-1:0] i_act,
    input  logic [DW-1:0] i_wt,
    input  logic [15:0]   i_bias,
    output logic [15:0]   o_res
);
    logic signed [2*DW-1:0]    w_prod;
    logic signed [ACC_WIDTH-1:0] w_prod_x, w_bias_x, w_max, w_min, r_acc;
    logic [15:0]               w_sat;

    assign w_prod   = $signed(i_act) * $signed(i_wt);
    assign w_prod_x = ACC_WIDTH'(w_prod);
    assign w_bias_x = ACC_WIDTH'($signed(i_bias));
    assign w_max    = ACC_WIDTH'(SAT_MAX);
    assign w_min    = ACC_WIDTH'(SAT_MIN);
    assign w_sat    = r_acc > w_max ? SAT_MAX : r_acc < w_min ? SAT_MIN : r_acc[15:0];

`ifdef FCSEQ_RELU_EN
    assign o_res = w_sat[15] ? 16'd0 : w_sat;
`else
    assign o_res = w_sat;
`endif

    // The first valid product of a neuron replaces the old sum with the bias.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_acc <= '0;
        else if (i_vld)
            r_acc <= (i_first ? w_bias_x : r_acc) + w_prod_x;
    end
endmodule

// File: rtl/fc_sequencer.sv
// fc_sequencer: walks a fully-connected layer neuron by neuron, streaming activations,
// weights and bias into fcseq_mac and handing each result off over valid/ready.
// Build option: FCSEQ_RELU_EN clamps negative results to zero.
module fc_sequencer
    import fcseq_pkg::*;
#(
    parameter int DATAWIDTH_BUS = 8,
    parameter int N_IN          = 16,
    parameter int N_OUT         = 10,
    parameter int ACC_WIDTH     = ACC_WIDTH_DEF
) (
    input  logic                             FCSEQ_CLOCK_50,
    input  logic                             FCSEQ_RESET_InHigh,
    input  logic                             FCSEQ_Start,
    output logic [$clog2(N_IN)-1:0]          FCSEQ_InAddr,
    input  logic [DATAWIDTH_BUS-1:0]         FCSEQ_InBUS,
    output logic [$clog2(N_IN*N_OUT)-1:0]    FCSEQ_WAddr,
    input  logic [DATAWIDTH_BUS-1:0]         FCSEQ_WBUS,
    output logic [$clog2(N_OUT)-1:0]         FCSEQ_BAddr,
    input  logic [15:0]                      FCSEQ_BBUS,
    output logic                             FCSEQ_RdEn,
    output logic [15:0]                      FCSEQ_OutBUS,
    output logic [$clog2(N_OUT)-1:0]         FCSEQ_OutIdx,
    output logic                             FCSEQ_OutValid,
    input  logic                             FCSEQ_OutReady,
    output logic                             FCSEQ_Busy,
    output logic                             FCSEQ_Done
);
    localparam int IW = $clog2(N_IN);
    localparam int WW = $clog2(N_IN * N_OUT);
    localparam int OW = $clog2(N_OUT);

    logic [2:0]    r_state;
    logic [IW-1:0] r_i;
    logic [OW-1:0] r_j;
    logic          r_vld, r_first;
    logic          w_last_i, w_last_j;
    logic [15:0]   w_res;

    assign w_last_i       = r_i == IW'(N_IN - 1);
    assign w_last_j       = r_j == OW'(N_OUT - 1);
    assign FCSEQ_RdEn     = r_state == S_MAC;
    assign FCSEQ_InAddr   = r_i;
    assign FCSEQ_WAddr    = WW'(32'(r_j) * N_IN + 32'(r_i));
    assign FCSEQ_BAddr    = r_j;
    assign FCSEQ_OutValid = r_state == S_OUT;
    assign FCSEQ_OutIdx   = r_j;
    assign FCSEQ_OutBUS   = FCSEQ_OutValid ? w_res : 16'd0;
    assign FCSEQ_Busy     = r_state != S_IDLE;
    assign FCSEQ_Done     = r_state == S_DONE;

    always_ff @(posedge FCSEQ_CLOCK_50 or posedge FCSEQ_RESET_InHigh) begin
        if (FCSEQ_RESET_InHigh) begin
            r_state <= S_IDLE;
            r_i     <= '0;
            r_j     <= '0;
            r_vld   <= 1'b0;
            r_first <= 1'b0;
        end else begin
            // Memories answer one cycle after the address, so data qualifiers lag RdEn.
            r_vld   <= FCSEQ_RdEn;
            r_first <= FCSEQ_RdEn && r_i == '0;
            case (r_state)
                S_IDLE: if (FCSEQ_Start) begin
                    r_state <= S_MAC;
                    r_i     <= '0;
                    r_j     <= '0;
                end
                S_MAC: begin
                    r_i     <= w_last_i ? '0 : r_i + 1'b1;
                    r_state <= w_last_i ? S_DRAIN : S_MAC;
                end
                S_DRAIN: r_state <= S_OUT;
                S_OUT: if (FCSEQ_OutReady) begin
                    r_state <= w_last_j ? S_DONE : S_MAC;
                    r_j     <= w_last_j ? r_j : r_j + 1'b1;
                    r_i     <= '0;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_j     <= '0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    fcseq_mac #(
        .DW        (DATAWIDTH_BUS),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_mac (
        .clk     (FCSEQ_CLOCK_50),
        .rst     (FCSEQ_RESET_InHigh),
        .i_vld   (r_vld),
        .i_first (r_first),
        .i_act   (FCSEQ_InBUS),
        .i_wt    (FCSEQ_WBUS),
        .i_bias  (FCSEQ_BBUS),
        .o_res   (w_res)
    );
endmodule

// File: tb/tb_fc_sequencer.sv
// tb_fc_sequencer: scoreboard bench for fc_sequencer; expected results are queued at
// stimulus time and popped by a monitor on each output handshake.
module tb_fc_sequencer;
    localparam int N_IN  = 16;
    localparam int N_OUT = 10;

    logic        clk = 0, rst = 1, start = 0, ready = 1;
    logic [3:0]  in_addr, b_addr, out_idx;
    logic [7:0]  w_addr;
    logic [7:0]  in_bus = 0, w_bus = 0;
    logic [15:0] b_bus = 0, out_bus;
    logic        rden, out_valid, busy, done;

    logic [7:0]  act  [N_IN];
    logic [7:0]  wt   [N_IN*N_OUT];
    logic [15:0] bias [N_OUT];
    logic [19:0] q[$];
    int checks = 0, errors = 0, done_cnt = 0, n_out = 0;

    always #5 clk = ~clk;

    fc_sequencer dut (
        .FCSEQ_CLOCK_50     (clk),
        .FCSEQ_RESET_InHigh (rst),
        .FCSEQ_Start        (start),
        .FCSEQ_InAddr       (in_addr),
        .FCSEQ_InBUS        (in_bus),
        .FCSEQ_WAddr        (w_addr),
        .FCSEQ_WBUS         (w_bus),
        .FCSEQ_BAddr        (b_addr),
        .FCSEQ_BBUS         (b_bus),
        .FCSEQ_RdEn         (rden),
        .FCSEQ_OutBUS       (out_bus),
        .FCSEQ_OutIdx       (out_idx),
        .FCSEQ_OutValid     (out_valid),
        .FCSEQ_OutReady     (ready),
        .FCSEQ_Busy         (busy),
        .FCSEQ_Done         (done)
    );

    always @(posedge clk) if (rden) begin
        in_bus <= act[in_addr];
        w_bus  <= wt[w_addr];
        b_bus  <= bias[b_addr];
    end

    always @(negedge clk) if (!rst) begin
        logic [19:0] e;
        if (done) done_cnt++;
        if (out_valid && ready) begin
            n_out++;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got idx %0d val %0h, expected none", out_idx, out_bus);
            end else begin
                e = q.pop_front();
                if ({out_idx, out_bus} !== e) begin
                    errors++;
                    $display("FAIL output: got idx %0d val %0h, expected idx %0d val %0h",
                             out_idx, out_bus, e[19:16], e[15:0]);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    task automatic fill(input logic [7:0] a, input logic [7:0] w, input logic [15:0] b);
        for (int i = 0; i < N_IN; i++) act[i] = a;
        for (int k = 0; k < N_IN*N_OUT; k++) wt[k] = w;
        for (int j = 0; j < N_OUT; j++) bias[j] = b;
    endtask

    task automatic push_const(input logic [15:0] v);
        for (int j = 0; j < N_OUT; j++) q.push_back({4'(j), v});
    endtask

    function automatic logic [15:0] satf(input int s);
        logic [15:0] r;
        r = s > 32767 ? 16'h7FFF : s < -32768 ? 16'h8000 : s[15:0];
`ifdef FCSEQ_RELU_EN
        if (s < 0) r = 16'h0000;
`endif
        return r;
    endfunction

    task automatic push_model();
        for (int j = 0; j < N_OUT; j++) begin
            int s;
            s = int'($signed(bias[j]));
            for (int i = 0; i < N_IN; i++)
                s += int'($signed(act[i])) * int'($signed(wt[j*N_IN+i]));
            q.push_back({4'(j), satf(s)});
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
    endtask

    task automatic wait_pass(input int d0, input string nm);
        int t = 0;
        while (done_cnt == d0 && t < 2000) begin
            @(posedge clk);
            t++;
        end
        @(negedge clk);
        chk({nm, "_done"}, done_cnt, d0 + 1);
        chk({nm, "_drained"}, q.size(), 0);
    endtask

    task automatic wait_valid(input string nm);
        int t = 0;
        @(negedge clk);
        while (!out_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk({nm, "_valid_seen"}, out_valid, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, n0, t;
        logic [15:0] hb;
        logic [3:0]  hi;
        fill(8'd1, 8'd1, 16'd0);
        #2;
        chk("rst_outvalid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rden", rden, 0);
        chk("rst_addrs", {in_addr, w_addr, b_addr}, 0);
        chk("rst_out", {out_idx, out_bus}, 0);

        push_const(16'd16);
        @(posedge clk); @(posedge clk); #1 rst = 0; start = 1;
        @(posedge clk); #1 start = 0;
        chk("first_start_busy", busy, 1);
        wait_pass(0, "ones");

        for (int i = 0; i < N_IN; i++) act[i] = 8'(i - 8);
        for (int j = 0; j < N_OUT; j++) begin
            bias[j] = 16'(100*j - 300);
            for (int i = 0; i < N_IN; i++) wt[j*N_IN+i] = 8'(3*j - i);
        end
        push_model();
        d0 = done_cnt; pulse_start(); wait_pass(d0, "pattern");

        fill(8'd127, 8'd127, 16'h7FFF);
        push_const(16'h7FFF);
        d0 = done_cnt; pulse_start(); wait_pass(d0, "sat_pos");

        fill(8'd127, 8'h80, 16'h8000);
`ifdef FCSEQ_RELU_EN
        push_const(16'h0000);
`else
        push_const(16'h8000);
`endif
        d0 = done_cnt; pulse_start(); wait_pass(d0, "sat_neg");

        fill(8'd1, 8'hFF, 16'hFFFC);
`ifdef FCSEQ_RELU_EN
        push_const(16'h0000);
`else
        push_const(16'hFFEC);
`endif
        d0 = done_cnt; pulse_start(); wait_pass(d0, "neg20");

        fill(8'd2, 8'd3, 16'd5);
        push_const(16'd101);
        d0 = done_cnt; ready = 0; pulse_start();
        wait_valid("stall");
        hb = out_bus; hi = out_idx;
        chk("stall_first_val", {hi, hb}, {4'd0, 16'd101});
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_hold", {out_valid, rden, out_idx, out_bus}, {1'b1, 1'b0, hi, hb});
        end
        @(posedge clk); #1 ready = 1;
        @(negedge clk);
        @(negedge clk);
        chk("stall_next_neuron", {rden, b_addr, in_addr}, {1'b1, 4'd1, 4'd0});
        wait_pass(d0, "stall");

        fill(8'd3, 8'hFE, 16'd7);
        push_const(16'hFFA7);
        pulse_start();
        t = 0;
        @(negedge clk);
        while (!(rden && b_addr == 4'd3 && in_addr == 4'd7) && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("abort_point_seen", {rden, b_addr, in_addr}, {1'b1, 4'd3, 4'd7});
        q.delete();
        #1 rst = 1;
        #1;
        chk("abort_ctrl", {out_valid, busy, done, rden}, 0);
        chk("abort_addrs", {in_addr, w_addr, b_addr}, 0);
        chk("abort_out", {out_idx, out_bus}, 0);
        @(posedge clk); #1 rst = 0;
        push_const(16'hFFA7);
        d0 = done_cnt; pulse_start(); wait_pass(d0, "after_abort");

        fill(8'd1, 8'd2, 16'hFFFF);
        push_const(16'd31);
        d0 = done_cnt; n0 = n_out;
        pulse_start();
        repeat (5) @(posedge clk);
        #1 start = 1;
        @(posedge clk); #1 start = 0;
        wait_valid("restart");
        start = 1;
        @(posedge clk); #1 start = 0;
        wait_pass(d0, "restart");
        chk("restart_count", n_out - n0, N_OUT);
        repeat (30) @(negedge clk);
        chk("restart_no_extra", {busy, 28'(done_cnt - d0)}, {1'b0, 28'd1});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
